pwm_timer: RTL and testbench
============================

Name: pwm_timer

Overview:
- PWM/period timer that consumes the divided clock from the programmable clock divider.
- The divided clock is sampled as a data signal in the i_clk domain. Each rising edge becomes a one-cycle tick.
- Ticks advance a period counter that produces a PWM waveform, a period-done pulse and a busy flag.
- Period, duty and mode come from the register file. They are captured into shadow registers only at period boundaries, so updates never glitch the output.

Parameters:
- CNT_W, 16, width of the period/duty counters and inputs.

Ports:
- i_clk  input  1  system clock; same clock that drives the divider.
- i_rst  input  1  synchronous, active-high reset.
- i_slow_clk  input  1  divided clock from the divider; sampled as data.
- i_en  input  1  timer enable from the register file; level-sensitive.
- i_oneshot  input  1  1 = stop after one period, 0 = continuous.
- i_period  input  CNT_W  period length in ticks; 0 = invalid/stop.
- i_duty  input  CNT_W  number of high ticks per period.
- i_irq_clr  input  1  clears the sticky interrupt; present only with PWM_IRQ_EN.
- o_pwm  output  1  PWM output, registered.
- o_period_done  output  1  one-cycle pulse when a period completes.
- o_busy  output  1  1 while in RUN.
- o_irq  output  1  sticky period-complete interrupt; present only with PWM_IRQ_EN.

Behaviour:
- Reset (i_rst=1 at a posedge i_clk):
  - slow_q=0, count=0, per_sh=0, duty_sh=0, os_sh=0, state=IDLE.
  - o_pwm=0, o_period_done=0, o_busy=0, o_irq=0.
  - Reset overrides every other input, including mid-period.
- Tick detection:
  - slow_q <= i_slow_clk every cycle.
  - tick = i_slow_clk & ~slow_q, so there is exactly one tick per divided-clock rising edge.
  - A stuck i_slow_clk (divisor 0 or 1 in the divider) gives no ticks: count freezes and o_pwm holds.
- State machine, 2 states:
  - IDLE -> RUN:
    - Transition when i_en=1 and i_period!=0.
    - Load per_sh=i_period, duty_sh=i_duty, os_sh=i_oneshot; set count=0.
    - o_busy=1 on the next cycle.
    - i_en=1 with i_period=0: remain in IDLE.
  - RUN with i_en=0 (highest priority in RUN):
    - Next cycle: IDLE, count=0, o_pwm=0, o_busy=0.
    - No o_period_done pulse.
  - RUN with tick and count==per_sh-1 (period end):
    - o_period_done=1 for one cycle; count=0.
    - If os_sh=1: go to IDLE.
    - Else if i_period==0: go to IDLE.
    - Else stay in RUN and reload the shadows from the current inputs.
  - RUN with tick, otherwise: count <= count+1.
  - No tick: hold all state.
- Output timing:
  - o_pwm is registered from next-state values: o_pwm <= (next_state==RUN) && (next_count < next_duty_sh).
  - Start latency: o_pwm rises 1 cycle after i_en is sampled high, when duty>0.
  - Each transition of o_pwm occurs 1 cycle after the causing tick.
- Boundary cases:
  - duty=0: o_pwm stays 0 for the whole period.
  - duty>=period: o_pwm stays 1 for the whole period, with no low gap at a continuous-mode boundary.
  - period=1: every tick ends a period; o_period_done pulses once per tick.
  - Input changes mid-period are ignored until the next boundary.
  - With tick and i_en=0 in the same cycle, i_en=0 wins.
- Arithmetic: comparisons are unsigned CNT_W. count never exceeds per_sh-1.

Optional Feature:
- Macro: PWM_IRQ_EN.
- With PWM_IRQ_EN defined:
  - Ports i_irq_clr and o_irq exist.
  - o_irq is set on any cycle where o_period_done=1 and cleared on i_irq_clr=1.
  - A simultaneous set and clear leaves o_irq=1 (set wins).
  - o_irq resets to 0.
- Without PWM_IRQ_EN: neither port nor the o_irq flop exists. All other behaviour is identical.

Test Plan:
- Continuous PWM:
  - Stimulus: i_slow_clk toggles every 2 i_clk; i_period=4, i_duty=1, i_en=1.
  - Response: o_pwm high for 4 i_clk then low for 12, repeating. o_period_done pulses every 16 i_clk; o_busy=1.
- One-shot:
  - Stimulus: i_oneshot=1, i_period=3, i_duty=2.
  - Response: exactly one o_period_done pulse. o_busy drops the cycle after that pulse; o_pwm=0 afterward.
- Duty boundaries:
  - duty=0 -> o_pwm never rises.
  - duty=5, period=4 -> o_pwm constant 1 across 3 periods.
  - period=0 with i_en=1 -> o_busy stays 0.
- Shadow update:
  - Stimulus: change i_duty 1->3 at count=2 of period=4.
  - Response: the current period keeps a 1-tick high; the next period has a 3-tick high.
- Abort and reset:
  - Drop i_en mid-period -> next cycle o_pwm=0, o_busy=0, no o_period_done.
  - Assert i_rst mid-period -> all outputs 0 on the next posedge.
  - Hold i_slow_clk constant -> count and o_pwm frozen.
- IRQ (PWM_IRQ_EN defined):
  - o_irq sets on the first o_period_done and stays set.
  - i_irq_clr in the same cycle as o_period_done -> o_irq remains 1.
  - i_irq_clr alone -> o_irq=0 on the next cycle.

Source files
------------

// File: rtl/pwm_timer.sv
// pwm_timer: tick-driven PWM/period timer with boundary-shadowed config; PWM_IRQ_EN adds sticky irq (i_irq_clr/o_irq)
module pwm_timer #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_slow_clk,
  input  logic             i_en,
  input  logic             i_oneshot,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
`ifdef PWM_IRQ_EN
  input  logic             i_irq_clr,
  output logic             o_irq,
`endif
  output logic             o_pwm,
  output logic             o_period_done,
  output logic             o_busy
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic             slow_q, tick, last;
  logic [CNT_W-1:0] count_q, count_d, per_sh_q, per_sh_d, duty_sh_q, duty_sh_d;
  logic             os_sh_q, os_sh_d, pwm_q, pwm_d;
  assign tick = i_slow_clk & ~slow_q;
  assign last = count_q == per_sh_q - CNT_W'(1);
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    per_sh_d      = per_sh_q;
    duty_sh_d     = duty_sh_q;
    os_sh_d       = os_sh_q;
    o_period_done = 1'b0;
    if (state_q == IDLE) begin
      if (i_en && i_period != '0) begin
        state_d   = RUN;
        count_d   = '0;
        per_sh_d  = i_period;
        duty_sh_d = i_duty;
        os_sh_d   = i_oneshot;
      end
    end else if (!i_en) begin
      state_d = IDLE;
      count_d = '0;
    end else if (tick) begin
      if (last) begin
        o_period_done = 1'b1;
        count_d       = '0;
        if (os_sh_q || i_period == '0) begin
          state_d = IDLE;
        end else begin
          per_sh_d  = i_period;
          duty_sh_d = i_duty;
          os_sh_d   = i_oneshot;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
    pwm_d = (state_d == RUN) && (count_d < duty_sh_d);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slow_q    <= 1'b0;
      state_q   <= IDLE;
      count_q   <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      os_sh_q   <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      slow_q    <= i_slow_clk;
      state_q   <= state_d;
      count_q   <= count_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      os_sh_q   <= os_sh_d;
      pwm_q     <= pwm_d;
    end
  end
  assign o_pwm  = pwm_q;
  assign o_busy = state_q == RUN;
`ifdef PWM_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = o_period_done | (irq_q & ~i_irq_clr);
  always_ff @(posedge i_clk) begin
    if (i_rst) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
  assign o_irq = irq_q;
`endif
endmodule

// File: tb/tb_pwm_timer.sv
// tb_pwm_timer: directed self-checking bench for pwm_timer
module tb_pwm_timer;
  logic        clk = 1'b0;
  logic        i_rst, i_slow_clk, i_en, i_oneshot;
  logic [15:0] i_period, i_duty;
  logic        o_pwm, o_period_done, o_busy;
`ifdef PWM_IRQ_EN
  logic        i_irq_clr, o_irq;
`endif
  int checks = 0;
  int failures = 0;
  pwm_timer #(.CNT_W(16)) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_slow_clk(i_slow_clk),
    .i_en(i_en),
    .i_oneshot(i_oneshot),
    .i_period(i_period),
    .i_duty(i_duty),
`ifdef PWM_IRQ_EN
    .i_irq_clr(i_irq_clr),
    .o_irq(o_irq),
`endif
    .o_pwm(o_pwm),
    .o_period_done(o_period_done),
    .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
    end
  endtask
  task automatic go(input logic s);
    i_slow_clk = s;
    @(posedge clk);
    #1;
  endtask
  task automatic tp(input logic ep, input logic ed);
    i_slow_clk = 1'b1;
    #1;
    chk("done_tick", o_period_done, ed);
    @(posedge clk);
    #1;
    chk("pwm_tick", o_pwm, ep);
    for (int i = 0; i < 3; i++) begin
      i_slow_clk = (i == 0);
      #1;
      chk("done_hold", o_period_done, 1'b0);
      @(posedge clk);
      #1;
      chk("pwm_hold", o_pwm, ep);
    end
  endtask
  initial begin
    i_rst = 1'b1; i_slow_clk = 1'b0; i_en = 1'b0; i_oneshot = 1'b0;
    i_period = 16'd0; i_duty = 16'd0;
`ifdef PWM_IRQ_EN
    i_irq_clr = 1'b0;
`endif
    go(0); go(0);
    chk("rst_pwm", o_pwm, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_period_done, 1'b0);
`ifdef PWM_IRQ_EN
    chk("rst_irq", o_irq, 1'b0);
`endif
    i_rst = 1'b0;
    i_period = 16'd4; i_duty = 16'd1; i_en = 1'b1;
    go(0);
    chk("start_pwm", o_pwm, 1'b1);
    chk("start_busy", o_busy, 1'b1);
    for (int p = 0; p < 2; p++) begin
      tp(0, 0); tp(0, 0); tp(0, 0); tp(1, 1);
    end
    chk("cont_busy", o_busy, 1'b1);
    tp(0, 0); tp(0, 0);
    i_duty = 16'd3;
    tp(0, 0); tp(1, 1);
    tp(1, 0); tp(1, 0); tp(0, 0); tp(1, 1);
    i_duty = 16'd5;
    tp(1, 0); tp(1, 0); tp(0, 0); tp(1, 1);
    for (int i = 0; i < 12; i++) tp(1, i % 4 == 3);
    i_duty = 16'd0;
    tp(1, 0); tp(1, 0); tp(1, 0); tp(0, 1);
    for (int i = 0; i < 8; i++) tp(0, i % 4 == 3);
    i_duty = 16'd2; i_en = 1'b0;
    go(0);
    chk("off_busy", o_busy, 1'b0);
    chk("off_pwm", o_pwm, 1'b0);
    i_en = 1'b1;
    go(0);
    chk("restart_pwm", o_pwm, 1'b1);
    tp(1, 0); tp(0, 0); tp(0, 0);
    i_en = 1'b0;
    i_slow_clk = 1'b1;
    #1;
    chk("abort_done", o_period_done, 1'b0);
    @(posedge clk);
    #1;
    chk("abort_pwm", o_pwm, 1'b0);
    chk("abort_busy", o_busy, 1'b0);
    go(1); go(0); go(0);
    chk("abort_idle", o_busy, 1'b0);
    i_period = 16'd0; i_en = 1'b1;
    tp(0, 0); tp(0, 0);
    chk("per0_busy", o_busy, 1'b0);
    i_period = 16'd4; i_duty = 16'd2;
    go(0);
    chk("stuck_start", o_pwm, 1'b1);
    tp(1, 0);
    for (int i = 0; i < 10; i++) begin
      go(0);
      chk("stuck_lo_pwm", o_pwm, 1'b1);
      chk("stuck_lo_done", o_period_done, 1'b0);
    end
    go(1);
    chk("stuck_tick", o_pwm, 1'b0);
    for (int i = 0; i < 10; i++) begin
      go(1);
      chk("stuck_hi_pwm", o_pwm, 1'b0);
      chk("stuck_hi_done", o_period_done, 1'b0);
    end
    go(0); go(0);
    tp(0, 0); tp(1, 1);
    i_period = 16'd1; i_duty = 16'd1;
    tp(1, 0); tp(0, 0); tp(0, 0); tp(1, 1);
    for (int i = 0; i < 4; i++) tp(1, 1);
    i_oneshot = 1'b1; i_period = 16'd3; i_duty = 16'd2;
    tp(1, 1); tp(1, 0); tp(0, 0);
    i_slow_clk = 1'b1;
    #1;
    chk("os_done", o_period_done, 1'b1);
    chk("os_busy_pre", o_busy, 1'b1);
    @(posedge clk);
    #1;
    chk("os_busy_post", o_busy, 1'b0);
    chk("os_pwm_post", o_pwm, 1'b0);
    i_en = 1'b0;
    go(1); go(0); go(0);
    tp(0, 0); tp(0, 0);
    chk("os_idle", o_busy, 1'b0);
    i_oneshot = 1'b0; i_period = 16'd4; i_duty = 16'd2; i_en = 1'b1;
    go(0);
    tp(1, 0);
    i_rst = 1'b1; i_en = 1'b0;
    go(0);
    chk("mid_rst_pwm", o_pwm, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_done", o_period_done, 1'b0);
    i_rst = 1'b0;
`ifdef PWM_IRQ_EN
    chk("mid_rst_irq", o_irq, 1'b0);
    i_period = 16'd1; i_duty = 16'd1; i_en = 1'b1;
    go(0);
    tp(1, 1);
    chk("irq_set", o_irq, 1'b1);
    go(0); go(0);
    chk("irq_sticky", o_irq, 1'b1);
    i_irq_clr = 1'b1;
    i_slow_clk = 1'b1;
    #1;
    chk("irq_coinc_done", o_period_done, 1'b1);
    @(posedge clk);
    #1;
    chk("irq_set_wins", o_irq, 1'b1);
    go(1);
    chk("irq_clr", o_irq, 1'b0);
    i_irq_clr = 1'b0;
    go(0);
    chk("irq_stay_clr", o_irq, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
